// File: rtl/prom_loader.sv
// rtl/prom_loader.sv - serial-loaded program memory that holds the core in reset while loading
// Optional checksum verification and FAIL state are enabled by `define PROM_CHECKSUM_EN.
module prom_loader #(
  parameter int PC_LEN    = 7,
  parameter int INSTR_LEN = 12
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SDI,
  input  logic                 SDV,
  input  logic                 LOAD_REQ,
  input  logic                 LOAD_END,
  input  logic [PC_LEN-1:0]    PC,
  output logic [INSTR_LEN-1:0] INSTR,
  output logic                 CORE_RSTN,
  output logic                 BUSY,
  output logic [PC_LEN:0]      WCNT,
  output logic                 ERR
);

  localparam int DEPTH = 2 ** PC_LEN;
  localparam int BW    = (INSTR_LEN > 1) ? $clog2(INSTR_LEN) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(INSTR_LEN - 1);
  localparam logic [PC_LEN:0] FULL     = (PC_LEN + 1)'(DEPTH);

`ifdef PROM_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN, S_FAIL} state_t;
`else
  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;
`endif

  state_t                 state, state_nxt;
  logic [BW-1:0]          bit_cnt;
  logic [INSTR_LEN-2:0]   shift;
  logic [PC_LEN-1:0]      waddr;
  logic [PC_LEN:0]        wcnt;
  logic                   rel_cnt;
  logic [INSTR_LEN-1:0]   word;
  logic                   full, word_done, load_start;
  logic                   core_rstn_nxt, busy_nxt;
  logic [INSTR_LEN-1:0]   mem [DEPTH];

`ifdef PROM_CHECKSUM_EN
  logic [INSTR_LEN-1:0]   sum, sum_nxt;
  logic                   err, err_nxt;
`endif

  always_comb begin
    word          = {shift, SDI};
    full          = (wcnt == FULL);
    word_done     = (state == S_LOAD) && SDV && !full && (bit_cnt == LAST_BIT);
    state_nxt     = state;
    load_start    = 1'b0;
    core_rstn_nxt = 1'b0;
    busy_nxt      = 1'b1;
`ifdef PROM_CHECKSUM_EN
    // The word completing on the LOAD_END edge must count toward the verdict.
    sum_nxt       = sum + (word_done ? word : '0);
    err_nxt       = 1'b0;
`endif
    case (state)
      S_LOAD: begin
        if (full || LOAD_END) begin
`ifdef PROM_CHECKSUM_EN
          if (sum_nxt != '0) begin
            state_nxt = S_FAIL;
            busy_nxt  = 1'b0;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = S_RELEASE;
          end
`else
          state_nxt = S_RELEASE;
`endif
        end
      end
      S_RELEASE: begin
        if (rel_cnt) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (LOAD_REQ) begin
          state_nxt  = S_LOAD;
          load_start = 1'b1;
        end else begin
          core_rstn_nxt = 1'b1;
          busy_nxt      = 1'b0;
        end
      end
`ifdef PROM_CHECKSUM_EN
      S_FAIL: begin
        if (LOAD_REQ) begin
          state_nxt  = S_LOAD;
          load_start = 1'b1;
        end else begin
          busy_nxt = 1'b0;
          err_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = S_LOAD;
    endcase
  end

  // Core-facing outputs are registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_LOAD;
      CORE_RSTN <= 1'b0;
      BUSY      <= 1'b1;
`ifdef PROM_CHECKSUM_EN
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      CORE_RSTN <= core_rstn_nxt;
      BUSY      <= busy_nxt;
`ifdef PROM_CHECKSUM_EN
      err       <= err_nxt;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || load_start) begin
      bit_cnt <= '0;
      shift   <= '0;
      waddr   <= '0;
      wcnt    <= '0;
      rel_cnt <= 1'b0;
`ifdef PROM_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      if ((state == S_LOAD) && SDV && !full) begin
        shift <= word[INSTR_LEN-2:0];
        if (word_done) begin
          bit_cnt <= '0;
          waddr   <= waddr + PC_LEN'(1);
          wcnt    <= wcnt + (PC_LEN + 1)'(1);
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
      rel_cnt <= (state == S_RELEASE) && !rel_cnt;
`ifdef PROM_CHECKSUM_EN
      sum     <= sum_nxt;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && word_done) mem[waddr] <= word;
  end

  assign INSTR = mem[PC];
  assign WCNT  = wcnt;
`ifdef PROM_CHECKSUM_EN
  assign ERR   = err;
`else
  assign ERR   = 1'b0;
`endif

endmodule

// File: doc/prom_loader.md
# prom_loader

Program memory that feeds the 8-bit core's instruction port. After reset it receives a program over a two-wire serial load interface (data bit plus valid) and writes it into an internal word array, holding the core in reset while it does so. Once the load ends it releases the core. It then serves `INSTR` combinationally from the core's `PC`, so it sits directly upstream of the core's fetch.

## Interface

**Parameters**
- `PC_LEN`, default 7: address width. Depth is `DEPTH = 2**PC_LEN` words.
- `INSTR_LEN`, default 12: instruction word width.

**Ports**
- `CLK` in, 1: single clock; all state updates on the rising edge.
- `RST` in, 1: reset, synchronous, active-high.
- `SDI` in, 1: serial load data bit, MSB of each word first.
- `SDV` in, 1: `SDI` is sampled on an edge only when `SDV`=1.
- `LOAD_REQ` in, 1: request a reload. Honoured only in RUN.
- `LOAD_END` in, 1: terminate the load. Honoured only in LOAD.
- `PC` in, `PC_LEN`: fetch address from the core.
- `INSTR` out, `INSTR_LEN`: instruction at `PC`.
- `CORE_RSTN` out, 1: registered active-low reset to the core.
- `BUSY` out, 1: high in LOAD and RELEASE.
- `WCNT` out, `PC_LEN+1`: number of words written in the current load.
- `ERR` out, 1: checksum failure (see Configuration).

## Operation

**States:** LOAD, RELEASE, RUN, and FAIL (FAIL exists only with the macro).

**Reset.** On an edge with `RST`=1:
- State goes to LOAD.
- Bit counter, shift register, write address and `WCNT` clear to 0.
- `CORE_RSTN`=0, `BUSY`=1, `ERR`=0.
- Memory contents are not reset and are retained.

**LOAD.**
- Each edge with `SDV`=1 shifts `SDI` into the shift register and increments the bit counter.
- On the edge that samples bit `INSTR_LEN-1` of a word:
  - `mem[waddr]` ← {shift[`INSTR_LEN-2`:0], `SDI`}.
  - `waddr` and `WCNT` increment; bit counter returns to 0.
- Full: when `WCNT` reaches `DEPTH`, the next edge moves the state to RELEASE. Further `SDV` is ignored.
- `LOAD_END`=1 moves the state to RELEASE on the next edge. Any partial word is discarded.
- `LOAD_END` and a word-completing `SDV` on the same edge: the word is written first, then the state moves to RELEASE.

**RELEASE.** Lasts exactly 2 cycles, then the state moves to RUN.

**RUN.**
- `CORE_RSTN`=1, `BUSY`=0.
- `LOAD_REQ`=1 moves the state to LOAD on the next edge. Counters clear and `CORE_RSTN` returns to 0 on that same edge.
- `SDV`, `SDI` and `LOAD_END` are ignored.

**Read port.**
- `INSTR` = `mem[PC]`, asynchronous read, in every state.
- A `PC` pointing at a location never written returns whatever that location holds; it is not forced to any value.

**Width rules.**
- `waddr` is `PC_LEN` bits and never wraps in use, because the full condition stops the load first.
- `WCNT` saturates at `DEPTH`.

## Timing

- Read latency is 0 cycles, combinational from `PC` to `INSTR`.
- Write: a word is visible on `INSTR` in the cycle after the edge that samples its last bit.
- Release: if `LOAD_END` is sampled at edge N, then `BUSY` and `CORE_RSTN` change on edge N+3. `CORE_RSTN` rises and `BUSY` falls at that edge.
- Reload: if `LOAD_REQ` is sampled at edge N, then `CORE_RSTN`=0 and `BUSY`=1 from edge N.
- Reset mid-load or mid-RELEASE: the block restarts in LOAD with counters at 0. Words already written stay in memory.
- `RST` has priority over all other inputs.

## Configuration

**`PROM_CHECKSUM_EN` defined:**
- A running sum of all written words, modulo 2^`INSTR_LEN`, is kept. It clears on entry to LOAD.
- The last word of each load is a checksum chosen so the total sum is 0.
- On leaving LOAD:
  - Sum ≠ 0: the state goes to FAIL. `ERR`=1, `CORE_RSTN` stays 0, `BUSY`=0.
  - Sum = 0: normal RELEASE.
- FAIL is left only by `LOAD_REQ`, which goes to LOAD and clears `ERR`, or by `RST`.

**Not defined:**
- No sum register and no FAIL state.
- `ERR` is tied to 0.

## Test plan

- **Reset:** hold `RST` 2 cycles → `CORE_RSTN`=0, `BUSY`=1, `WCNT`=0, `ERR`=0.
- **Normal load:** shift words 0x123, 0x456, 0xA87, then `LOAD_END` at edge N → `WCNT`=3; `PC`=1 gives `INSTR`=0x456; `CORE_RSTN` rises at N+3; `ERR`=0 in both builds.
- **Partial word:** load 1 word, then 5 bits, then `LOAD_END` → `WCNT`=1; address 1 keeps its previous content.
- **Full:** stream 128 words without `LOAD_END` → RELEASE entered automatically; the 129th word's bits are ignored; `WCNT`=128.
- **Reload and reset mid-load:** in RUN, pulse `LOAD_REQ` → `CORE_RSTN` falls the same edge. Assert `RST` after 2 of 3 words → `WCNT`=0, words 0–1 retained.
- **Checksum (`PROM_CHECKSUM_EN`):** load 0x123, 0x456, 0x000, then `LOAD_END` → `ERR`=1, `CORE_RSTN` stays 0; a following `LOAD_REQ` clears `ERR`.
